// File: rtl/cam_pkg.sv
// Shared types for the my_cam request scheduler.
// Default CAM geometry, write request bundle and write FSM states.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 24;
  localparam int CAM_ADDR_WIDTH = 9;

  typedef struct packed {
    logic                      del;
    logic [CAM_ADDR_WIDTH-1:0] addr;
    logic [CAM_DATA_WIDTH-1:0] data;
  } cam_wr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } cam_wr_state_t;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock FIFO holding queued CAM write requests.
// Extra pointer bit separates full from empty; push+pop allowed when full.
module cam_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp == rp);
  assign full    = ((wp ^ rp) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_req_sched.sv
// Request scheduler in front of my_cam: paced write queue plus
// a fixed-latency lookup pipe returning tagged, in-order responses.
module cam_req_sched
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int TAG_WIDTH  = 4,
  parameter int WQ_DEPTH   = 4,
  parameter int LOOKUP_LAT = 4,
  parameter int WR_HOLD    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_delete,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [DATA_WIDTH-1:0] lk_data,
  input  logic [TAG_WIDTH-1:0]  lk_tag,
  output logic                  rsp_valid,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH-1:0] write_addr_wire,
  output logic [DATA_WIDTH-1:0] write_data_wire,
  output logic                  write_delete_wire,
  output logic                  write_enable_wire,
  output logic [DATA_WIDTH-1:0] compare_data_wire,
  input  logic                  write_busy_reg,
  input  logic                  match_reg,
  input  logic [ADDR_WIDTH-1:0] match_addr_reg
);

  localparam int CW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  cam_wr_state_t state;
  cam_wr_req_t   push_req;
  cam_wr_req_t   head;
  logic          q_full;
  logic          q_empty;
  logic          pop;
  logic          lk_hs;
  logic [CW-1:0] hold_cnt;

  logic [LOOKUP_LAT-1:0]                pipe_v;
  logic [LOOKUP_LAT-1:0][TAG_WIDTH-1:0] pipe_tag;

  assign push_req = '{del: wr_delete, addr: wr_addr, data: wr_data};
  assign wr_ready = !q_full;
  assign pop      = (state == IDLE) && !q_empty && !write_busy_reg;
  // Lookups only issue once every accepted write has fully drained.
  assign lk_ready = (state == IDLE) && q_empty;
  assign lk_hs    = lk_valid && lk_ready;

  cam_sync_fifo #(
    .WIDTH ($bits(cam_wr_req_t)),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid && wr_ready),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      hold_cnt          <= '0;
      write_addr_wire   <= '0;
      write_data_wire   <= '0;
      write_delete_wire <= 1'b0;
      write_enable_wire <= 1'b0;
    end else begin
      write_enable_wire <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            write_addr_wire   <= head.addr;
            write_data_wire   <= head.data;
            write_delete_wire <= head.del;
            write_enable_wire <= 1'b1;
            hold_cnt          <= '0;
            state             <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == CW'(WR_HOLD - 1)) state <= WAIT;
          else hold_cnt <= hold_cnt + CW'(1);
        end
        WAIT: begin
          if (!write_busy_reg) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare_data_wire <= '0;
      pipe_v            <= '0;
      pipe_tag          <= '0;
      rsp_valid         <= 1'b0;
      rsp_tag           <= '0;
      rsp_hit           <= 1'b0;
      rsp_addr          <= '0;
    end else begin
      if (lk_hs) compare_data_wire <= lk_data;
      pipe_v[0]   <= lk_hs;
      pipe_tag[0] <= lk_tag;
      for (int i = 1; i < LOOKUP_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      // Match result is sampled in the cycle it becomes valid.
      rsp_valid <= pipe_v[LOOKUP_LAT-1];
      rsp_tag   <= pipe_v[LOOKUP_LAT-1] ? pipe_tag[LOOKUP_LAT-1] : '0;
      rsp_hit   <= pipe_v[LOOKUP_LAT-1] && match_reg;
      rsp_addr  <= (pipe_v[LOOKUP_LAT-1] && match_reg) ? match_addr_reg : '0;
    end
  end

endmodule
